// File: rtl/text_console_writer.sv
// text_console_writer: turns a CPU byte stream into writes to a COLS x ROWS character buffer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   charIn/charValid/charReady  byte input handshake (transfer when charValid && charReady)
//   writeIndex/writeData/writeEnable  one-cell write port into the character buffer
//   scrollIndex/scrollData   buffer read port used while scrolling (data one cycle after address)
//   cursorIndex              current cursor cell for the renderer
// Build option: define CONSOLE_SCROLL_EN to scroll on overflow; otherwise the cursor wraps to cell 0.
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  charIn,
  input  logic        charValid,
  output logic        charReady,
  output logic [13:0] writeIndex,
  output logic [7:0]  writeData,
  output logic        writeEnable,
  output logic [13:0] scrollIndex,
  input  logic [7:0]  scrollData,
  output logic [13:0] cursorIndex
);
  localparam logic [13:0] COLS_W = 14'(COLS);
  localparam logic [13:0] LAST_CELL = 14'(COLS * ROWS - 1);
  localparam logic [13:0] LAST_ROW = 14'((ROWS - 1) * COLS);
  localparam logic [7:0] SPACE = 8'h20;
`ifdef CONSOLE_SCROLL_EN
  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_COPY, SCROLL_BLANK} state_t;
  logic [13:0] sidx;
  logic wsrc;
`else
  typedef enum logic [1:0] {CLEAR, IDLE, WRAP} state_t;
  logic unused_scroll;
  assign unused_scroll = ^scrollData;
`endif
  state_t state, next_state;
  logic [13:0] cnt, cur, col, widx;
  logic [7:0] wd;
  logic we, fire, printable, is_lf, is_cr, is_bs, overflow;

  assign fire = charValid && charReady;
  assign printable = charIn >= 8'h20 && charIn <= 8'h7E;
  assign is_lf = charIn == 8'h0A;
  assign is_cr = charIn == 8'h0D;
  assign is_bs = charIn == 8'h08 && col != '0;
  // only a printable on the last cell or a line feed on the last row can push the cursor off the screen
  assign overflow = fire && ((printable && cur == LAST_CELL) || (is_lf && cur >= LAST_ROW));

  always_ff @(posedge clk) state <= rst ? CLEAR : next_state;

  always_comb begin
    next_state = state;
    case (state)
      CLEAR: next_state = cnt == LAST_CELL ? IDLE : CLEAR;
`ifdef CONSOLE_SCROLL_EN
      IDLE: next_state = overflow ? SCROLL_COPY : IDLE;
      SCROLL_COPY: next_state = sidx == LAST_CELL ? SCROLL_BLANK : SCROLL_COPY;
      SCROLL_BLANK: next_state = cnt == LAST_CELL ? IDLE : SCROLL_BLANK;
`else
      IDLE: next_state = overflow ? WRAP : IDLE;
      WRAP: next_state = IDLE;
`endif
      default: next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      cur <= '0;
      col <= '0;
      widx <= '0;
      wd <= SPACE;
      we <= 1'b0;
`ifdef CONSOLE_SCROLL_EN
      sidx <= '0;
      wsrc <= 1'b0;
`endif
    end else begin
      we <= 1'b0;
`ifdef CONSOLE_SCROLL_EN
      wsrc <= 1'b0;
`endif
      case (state)
        CLEAR: begin
          we <= 1'b1;
          widx <= cnt;
          wd <= SPACE;
          cnt <= cnt == LAST_CELL ? '0 : cnt + 14'd1;
        end
        IDLE: if (fire) begin
          if (printable) begin
            we <= 1'b1;
            widx <= cur;
            wd <= charIn;
          end else if (is_bs) begin
            we <= 1'b1;
            widx <= cur - 14'd1;
            wd <= SPACE;
          end
          // on overflow the cursor stays on-screen until the handling state repositions it
          if (!overflow) begin
            cur <= printable ? cur + 14'd1 : is_lf ? cur + COLS_W - col : is_cr ? cur - col : is_bs ? cur - 14'd1 : cur;
            col <= printable ? (col == COLS_W - 14'd1 ? '0 : col + 14'd1) : (is_lf || is_cr) ? '0 : is_bs ? col - 14'd1 : col;
          end
`ifdef CONSOLE_SCROLL_EN
          if (overflow) begin
            sidx <= COLS_W;
            cnt <= LAST_ROW;
          end
`endif
        end
`ifdef CONSOLE_SCROLL_EN
        SCROLL_COPY: begin
          // the read issued last cycle returns now; the write target trails the read address by one row
          we <= 1'b1;
          wsrc <= 1'b1;
          widx <= sidx - COLS_W;
          sidx <= sidx == LAST_CELL ? '0 : sidx + 14'd1;
        end
        SCROLL_BLANK: begin
          we <= 1'b1;
          widx <= cnt;
          wd <= SPACE;
          if (cnt == LAST_CELL) begin
            cnt <= '0;
            cur <= LAST_ROW;
            col <= '0;
          end else cnt <= cnt + 14'd1;
        end
`else
        WRAP: begin
          cur <= '0;
          col <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    charReady = state == IDLE;
`ifdef CONSOLE_SCROLL_EN
    writeData = wsrc ? scrollData : wd;
`else
    writeData = wd;
`endif
  end

  assign writeEnable = we;
  assign writeIndex = widx;
  assign cursorIndex = cur;
`ifdef CONSOLE_SCROLL_EN
  assign scrollIndex = sidx;
`else
  assign scrollIndex = '0;
`endif
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: self-checking bench for text_console_writer against a screen-level model.
// Provides the character buffer RAM (one-cycle read latency) and follows CONSOLE_SCROLL_EN like the DUT.
module tb_text_console_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int TOTAL = COLS * ROWS;
  localparam int LAST = (ROWS - 1) * COLS;

  logic clk = 1'b0, rst = 1'b1, charValid = 1'b0;
  logic charReady, writeEnable;
  logic [7:0] charIn = 8'h00, writeData, scrollData = 8'h00;
  logic [13:0] writeIndex, scrollIndex, cursorIndex;
  logic [7:0] mem [TOTAL];
  logic [7:0] model [TOTAL];
  int mcur = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .charIn(charIn), .charValid(charValid), .charReady(charReady),
    .writeIndex(writeIndex), .writeData(writeData), .writeEnable(writeEnable),
    .scrollIndex(scrollIndex), .scrollData(scrollData), .cursorIndex(cursorIndex)
  );

  always @(posedge clk) begin
    scrollData <= mem[scrollIndex];
    if (writeEnable) mem[writeIndex] <= writeData;
  end

  function automatic bit model_apply(input logic [7:0] c);
    int col;
    col = mcur % COLS;
    if (c >= 8'h20 && c <= 8'h7E) begin
      model[mcur] = c;
      mcur++;
    end else if (c == 8'h0A) mcur = (mcur / COLS + 1) * COLS;
    else if (c == 8'h0D) mcur -= col;
    else if (c == 8'h08 && col != 0) begin
      mcur--;
      model[mcur] = 8'h20;
    end
    if (mcur == TOTAL) begin
`ifdef CONSOLE_SCROLL_EN
      for (int i = 0; i < LAST; i++) model[i] = model[i + COLS];
      for (int i = LAST; i < TOTAL; i++) model[i] = 8'h20;
      mcur = LAST;
`else
      mcur = 0;
`endif
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int mem_diff();
    int d;
    d = 0;
    for (int i = 0; i < TOTAL; i++) if (mem[i] !== model[i]) d++;
    return d;
  endfunction

  task automatic fill_to_end();
    charValid = 1'b1;
    while (mcur < TOTAL - 1) begin
      charIn = 8'($urandom_range(32, 126));
      void'(model_apply(charIn));
      @(negedge clk);
    end
    charValid = 1'b0;
  endtask

  task automatic test_reset(input string tag);
    int bad, first, d;
    rst = 1'b1;
    charValid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (writeEnable !== 1'b0 || charReady !== 1'b0 || cursorIndex !== 14'd0 || scrollIndex !== 14'd0) begin
      errors++;
      $display("FAIL %s_reset_state we=%b ready=%b cursor=%0d sidx=%0d want 0 0 0 0", tag, writeEnable, charReady, cursorIndex, scrollIndex);
    end
    for (int i = 0; i < TOTAL; i++) model[i] = 8'h20;
    mcur = 0;
    rst = 1'b0;
    bad = 0;
    first = -1;
    for (int k = 0; k < TOTAL; k++) begin
      @(negedge clk);
      if (writeEnable !== 1'b1 || writeIndex !== 14'(k) || writeData !== 8'h20) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_clear_seq bad_cycles=%0d first_bad=%0d want 0 bad cycles", tag, bad, first);
    end
    @(negedge clk);
    checks++;
    if (charReady !== 1'b1 || cursorIndex !== 14'd0 || writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear_done ready=%b cursor=%0d we=%b want 1 0 0", tag, charReady, cursorIndex, writeEnable);
    end
    d = mem_diff();
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL %s_clear_mem diff_cells=%0d want 0", tag, d);
    end
  endtask

  task automatic test_back_to_back();
    charValid = 1'b1;
    charIn = 8'h41;
    void'(model_apply(charIn));
    @(negedge clk);
    checks++;
    if (writeEnable !== 1'b1 || writeIndex !== 14'd0 || writeData !== 8'h41 || charReady !== 1'b1) begin
      errors++;
      $display("FAIL b2b_A we=%b idx=%0d data=%h ready=%b want 1 0 41 1", writeEnable, writeIndex, writeData, charReady);
    end
    charIn = 8'h42;
    void'(model_apply(charIn));
    @(negedge clk);
    charValid = 1'b0;
    checks++;
    if (writeEnable !== 1'b1 || writeIndex !== 14'd1 || writeData !== 8'h42 || cursorIndex !== 14'd2) begin
      errors++;
      $display("FAIL b2b_B we=%b idx=%0d data=%h cursor=%0d want 1 1 42 2", writeEnable, writeIndex, writeData, cursorIndex);
    end
    @(negedge clk);
    checks++;
    if (writeEnable !== 1'b0 || cursorIndex !== 14'd2) begin
      errors++;
      $display("FAIL b2b_idle we=%b cursor=%0d want 0 2", writeEnable, cursorIndex);
    end
  endtask

  task automatic test_controls();
    logic [7:0] cs [4] = '{8'h58, 8'h0A, 8'h08, 8'h59};
    logic ews [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [13:0] eis [4] = '{14'd0, 14'd0, 14'd0, 14'd80};
    logic [13:0] ecs [4] = '{14'd1, 14'd80, 14'd80, 14'd81};
    test_reset("ctl");
    charValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      charIn = cs[i];
      void'(model_apply(charIn));
      @(negedge clk);
      checks++;
      if (writeEnable !== ews[i] || (ews[i] && (writeIndex !== eis[i] || writeData !== cs[i])) || cursorIndex !== ecs[i]) begin
        errors++;
        $display("FAIL ctl_step%0d we=%b idx=%0d data=%h cursor=%0d want %b %0d %h %0d", i, writeEnable, writeIndex, writeData, cursorIndex, ews[i], eis[i], cs[i], ecs[i]);
      end
    end
    charValid = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] c, edata;
    logic ewe;
    int prev, eidx, sel, d;
    for (int n = 0; n < 300; n++) begin
      if (mcur >= LAST) break;
      sel = $urandom_range(0, 99);
      c = sel < 60 ? 8'($urandom_range(32, 126)) : sel < 68 ? 8'h0A : sel < 76 ? 8'h0D : sel < 88 ? 8'h08 : 8'($urandom_range(0, 255));
      charValid = $urandom_range(0, 7) != 0;
      charIn = c;
      prev = mcur;
      ewe = 1'b0;
      eidx = 0;
      edata = 8'h20;
      if (charValid) begin
        ewe = (c >= 8'h20 && c <= 8'h7E) || (c == 8'h08 && prev % COLS != 0);
        void'(model_apply(c));
        eidx = (c >= 8'h20 && c <= 8'h7E) ? prev : mcur;
        edata = (c >= 8'h20 && c <= 8'h7E) ? c : 8'h20;
      end
      @(negedge clk);
      checks++;
      if (writeEnable !== ewe || (ewe && (writeIndex !== 14'(eidx) || writeData !== edata)) || cursorIndex !== 14'(mcur)) begin
        errors++;
        $display("FAIL rand_%0d byte=%h valid=%b we=%b idx=%0d data=%h cursor=%0d want %b %0d %h %0d", n, c, charValid, writeEnable, writeIndex, writeData, cursorIndex, ewe, eidx, edata, mcur);
      end
    end
    charValid = 1'b0;
    @(negedge clk);
    d = mem_diff();
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL rand_mem diff_cells=%0d want 0", d);
    end
  endtask

  task automatic test_overflow();
    int bad, rbad, writes, d, prev;
    test_reset("ovf");
    fill_to_end();
    charValid = 1'b1;
    charIn = 8'h5A;
    void'(model_apply(charIn));
    @(negedge clk);
    charValid = 1'b0;
    checks++;
    if (writeEnable !== 1'b1 || writeIndex !== 14'(TOTAL - 1) || writeData !== 8'h5A) begin
      errors++;
      $display("FAIL ovf_last_write we=%b idx=%0d data=%h want 1 %0d 5a", writeEnable, writeIndex, writeData, TOTAL - 1);
    end
    checks++;
    if (charReady !== 1'b0 || cursorIndex >= 14'(TOTAL)) begin
      errors++;
      $display("FAIL ovf_busy ready=%b cursor=%0d want 0 and cursor<%0d", charReady, cursorIndex, TOTAL);
    end
`ifdef CONSOLE_SCROLL_EN
    bad = 0;
    rbad = 0;
    for (int k = 0; k < TOTAL; k++) begin
      @(negedge clk);
      if (writeEnable !== 1'b1 || writeIndex !== 14'(k) || writeData !== model[k]) bad++;
      if (k < TOTAL - 1 && charReady !== 1'b0) rbad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL scroll_writes bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (rbad != 0) begin
      errors++;
      $display("FAIL scroll_ready_low ready_cycles=%0d want 0", rbad);
    end
    @(negedge clk);
    checks++;
    if (charReady !== 1'b1 || cursorIndex !== 14'(LAST) || writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL scroll_done ready=%b cursor=%0d we=%b want 1 %0d 0", charReady, cursorIndex, writeEnable, LAST);
    end
`else
    @(negedge clk);
    checks++;
    if (charReady !== 1'b1 || cursorIndex !== 14'd0 || writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done ready=%b cursor=%0d we=%b want 1 0 0", charReady, cursorIndex, writeEnable);
    end
    writes = 0;
    repeat (5) begin
      @(negedge clk);
      if (writeEnable !== 1'b0) writes++;
    end
    checks++;
    if (writes != 0) begin
      errors++;
      $display("FAIL wrap_quiet writes=%0d want 0", writes);
    end
`endif
    d = mem_diff();
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL ovf_mem diff_cells=%0d want 0", d);
    end
    charValid = 1'b1;
    charIn = 8'h51;
    prev = mcur;
    void'(model_apply(charIn));
    @(negedge clk);
    charValid = 1'b0;
    checks++;
    if (writeEnable !== 1'b1 || writeIndex !== 14'(prev) || writeData !== 8'h51 || cursorIndex !== 14'(mcur)) begin
      errors++;
      $display("FAIL ovf_after we=%b idx=%0d data=%h cursor=%0d want 1 %0d 51 %0d", writeEnable, writeIndex, writeData, cursorIndex, prev, mcur);
    end
  endtask

  task automatic test_reset_mid_scroll();
    test_reset("mid");
    fill_to_end();
    charValid = 1'b1;
    charIn = 8'h5A;
    void'(model_apply(charIn));
    @(negedge clk);
    charValid = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (writeEnable !== 1'b0 || charReady !== 1'b0 || cursorIndex !== 14'd0 || scrollIndex !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset we=%b ready=%b cursor=%0d sidx=%0d want 0 0 0 0", writeEnable, charReady, cursorIndex, scrollIndex);
    end
    test_reset("mid_clear");
  endtask

  initial begin
    test_reset("init");
    test_back_to_back();
    test_controls();
    test_random();
    test_overflow();
    test_reset_mid_scroll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
